// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath widths, HALT opcode, bubble encoding,
// fetch FSM states and the IF/ID payload.
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 8;
  localparam int unsigned OPC_W   = 4;

  localparam logic [OPC_W-1:0]   OPC_HALT  = 4'hF;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } if_id_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W] == OPC_HALT;
  endfunction

endpackage

// File: rtl/imem.sv
// Instruction memory: asynchronous read, synchronous write, contents never reset.
import cpu_pkg::*;

module imem #(
  parameter int unsigned DEPTH = 256
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PC_W-1:0]    waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [PC_W-1:0]    raddr,
  output logic [INSTR_W-1:0] rdata_c
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // A write and a read of the same word in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, RUN/HALTED fetch FSM and the IF/ID pipeline register,
// fed by the imem array.
import cpu_pkg::*;

module if_stage #(
  parameter int unsigned        IMEM_DEPTH = 256,
  parameter logic [INSTR_W-1:0] NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid,
  output logic               halted
);

  localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc: '0, valid: 1'b0};

  logic [PC_W-1:0]    pc_q, pc_d;
  if_id_t             if_id_q, if_id_d;
  state_e             state_q, state_d;
  logic [INSTR_W-1:0] fetch_instr;

  imem #(
    .DEPTH (IMEM_DEPTH)
  ) u_imem (
    .clk     (clk),
    .we      (imem_we),
    .waddr   (imem_waddr),
    .wdata   (imem_wdata),
    .raddr   (pc_q),
    .rdata_c (fetch_instr)
  );

  // Redirect wins over everything but reset; a HALT word is latched but freezes the PC.
  always_comb begin
    pc_d    = pc_q;
    if_id_d = if_id_q;
    state_d = state_q;
    if (flush) begin
      pc_d    = branch_target;
      if_id_d = BUBBLE;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (!stall) begin
            if_id_d = '{instr: fetch_instr, pc: pc_q, valid: 1'b1};
            if (is_halt(fetch_instr)) begin
              state_d = HALTED;
            end else begin
              pc_d = pc_q + PC_W'(1);
            end
          end
        end
        HALTED:  if_id_d = BUBBLE;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      if_id_q <= BUBBLE;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
      state_q <= state_d;
    end
  end

  assign pc          = pc_q;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc    = if_id_q.pc;
  assign if_id_valid = if_id_q.valid;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a per-cycle vector table plus hand-written reset sequences.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, imem_we;
  logic [7:0]  branch_target, imem_waddr;
  logic [15:0] imem_wdata;
  logic [7:0]  pc, if_id_pc;
  logic [15:0] if_id_instr;
  logic        if_id_valid, halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall, flush;
    logic [7:0]  tgt;
    logic        we;
    logic [7:0]  waddr;
    logic [15:0] wdata;
    logic [7:0]  e_pc;
    logic [15:0] e_instr;
    logic        chk_ifpc;
    logic [7:0]  e_ifpc;
    logic        e_valid, e_halted;
  } vec_t;

  vec_t vecs[$];

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_we       (imem_we),
    .imem_waddr    (imem_waddr),
    .imem_wdata    (imem_wdata),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_pc, input logic [15:0] e_instr,
                           input logic chk_ifpc, input logic [7:0] e_ifpc,
                           input logic e_valid, input logic e_halted);
    check({tag, ".pc"}, 16'(pc), 16'(e_pc));
    check({tag, ".instr"}, if_id_instr, e_instr);
    if (chk_ifpc) check({tag, ".ifpc"}, 16'(if_id_pc), 16'(e_ifpc));
    check({tag, ".valid"}, 16'(if_id_valid), 16'(e_valid));
    check({tag, ".halted"}, 16'(halted), 16'(e_halted));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic s, input logic f, input logic [7:0] t,
                              input logic w, input logic [7:0] wa, input logic [15:0] wd,
                              input logic [7:0] epc, input logic [15:0] ei, input logic ci,
                              input logic [7:0] eip, input logic ev, input logic eh);
    vec_t v;
    v.stall = s; v.flush = f; v.tgt = t; v.we = w; v.waddr = wa; v.wdata = wd;
    v.e_pc = epc; v.e_instr = ei; v.chk_ifpc = ci; v.e_ifpc = eip;
    v.e_valid = ev; v.e_halted = eh;
    return v;
  endfunction

  initial begin
    logic [7:0]  la [8];
    logic [15:0] ld [8];
    la = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'hFF};
    ld = '{16'h1123, 16'h2345, 16'h4567, 16'h1789, 16'h1444, 16'hF000, 16'h1616, 16'h1111};

    //          stall flush tgt   we waddr  wdata     pc     instr     ci ifpc   v  h
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h01, 16'h1123, 1, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h02, 16'h2345, 1, 8'h01, 1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h02, 16'h2345, 1, 8'h01, 1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1, 8'h11, 16'h1717, 8'h02, 16'h2345, 1, 8'h01, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h03, 16'h4567, 1, 8'h02, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h04, 16'h1789, 1, 8'h03, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h05, 16'h1444, 1, 8'h04, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h05, 16'hF000, 1, 8'h05, 1, 1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h05, 16'h0000, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h05, 16'h0000, 0, 8'h00, 0, 1));
    vecs.push_back(mk(1, 1, 8'h10, 0, 8'h00, 16'h0000, 8'h10, 16'h0000, 1, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h11, 16'h1616, 1, 8'h10, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h12, 16'h1717, 1, 8'h11, 1, 0));
    vecs.push_back(mk(0, 1, 8'h00, 0, 8'h00, 16'h0000, 8'h00, 16'h0000, 1, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h01, 16'h1123, 1, 8'h00, 1, 0));
    vecs.push_back(mk(0, 1, 8'hFF, 0, 8'h00, 16'h0000, 8'hFF, 16'h0000, 1, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h00, 16'h1111, 1, 8'hFF, 1, 0));
    // Write imem[0] while fetching it: the old word is fetched.
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h00, 16'h2222, 8'h01, 16'h1123, 1, 8'h00, 1, 0));
    vecs.push_back(mk(0, 1, 8'hFF, 0, 8'h00, 16'h0000, 8'hFF, 16'h0000, 1, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h00, 16'h1111, 1, 8'hFF, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h01, 16'h2222, 1, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 16'h0000, 8'h02, 16'h2345, 1, 8'h01, 1, 0));

    reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = '0;
    imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;

    // Program load while held in reset, with stall/flush asserted to show reset dominates.
    for (int i = 0; i < 8; i++) begin
      imem_we = 1'b1; imem_waddr = la[i]; imem_wdata = ld[i];
      stall = i[0]; flush = i[1]; branch_target = 8'h33;
      tick();
    end
    imem_we = 1'b0; stall = 1'b0; flush = 1'b0;
    check_all("reset", 8'h00, 16'h0000, 1, 8'h00, 0, 0);

    reset = 1'b0;
    foreach (vecs[i]) begin
      stall = vecs[i].stall; flush = vecs[i].flush; branch_target = vecs[i].tgt;
      imem_we = vecs[i].we; imem_waddr = vecs[i].waddr; imem_wdata = vecs[i].wdata;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].chk_ifpc,
                vecs[i].e_ifpc, vecs[i].e_valid, vecs[i].e_halted);
    end
    imem_we = 1'b0; stall = 1'b0; flush = 1'b0;

    // Reset mid-run with stall held.
    reset = 1'b1; stall = 1'b1;
    tick();
    check_all("rst_mid", 8'h00, 16'h0000, 1, 8'h00, 0, 0);

    // Reset while the HALT word sits at pc: no halt, pc cleared.
    reset = 1'b0; stall = 1'b0; flush = 1'b1; branch_target = 8'h05;
    tick();
    check_all("to_halt", 8'h05, 16'h0000, 1, 8'h00, 0, 0);
    flush = 1'b0; reset = 1'b1;
    tick();
    check_all("rst_halt", 8'h00, 16'h0000, 1, 8'h00, 0, 0);

    // First edge after release fetches imem[0].
    reset = 1'b0;
    tick();
    check_all("post_rst", 8'h01, 16'h2222, 1, 8'h00, 1, 0);

    // Write during flush lands in memory.
    flush = 1'b1; branch_target = 8'h40;
    imem_we = 1'b1; imem_waddr = 8'h40; imem_wdata = 16'h4040;
    tick();
    flush = 1'b0; imem_we = 1'b0;
    tick();
    check_all("wr_flush", 8'h41, 16'h4040, 1, 8'h40, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
